// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl -- multi-cycle MIPS-subset control unit.
//
// Sequences each instruction through IF/ID/EX/MEM/WB and decodes the
// datapath controls from the current state, opcode, function field and the
// ALU equality flag. Also counts retired instructions.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   run               fetch enable, looked at only in IF
//   Op, Funct, Zero   IR[31:26], IR[5:0], ALU equality flag
//   PCWrite, IRWrite, RegWrite, MemWrite, MemRead   write/read strobes
//   RegDst            00 rt, 01 rd, 10 r31
//   ALUSrc, ALUSrc2   extended imm as operand B / rt as operand A (sll)
//   ExtOp             1 = sign-extend immediate
//   ALUCtr            ADD=0 SUB=1 AND=2 OR=3 SLT=4 SLL=5 LUI=6
//   Data_to_Reg_sel   00 ALU, 01 memory, 10 PC+4
//   PC_sel            00 PC+4, 01 branch target, 10 jump target
//   IsJump            jump in progress
//   state             current state (IF=0 ID=1 EX=2 MEM=3 WB=4)
//   done              last cycle of an instruction (same as PCWrite)
//   illegal           undecoded instruction in ID
//   instr_cnt         retired-instruction count, wraps
// -----------------------------------------------------------------------------
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic [5:0]       Op,
   input  logic [5:0]       Funct,
   input  logic             Zero,
   output logic             PCWrite,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             MemRead,
   output logic [1:0]       RegDst,
   output logic             ALUSrc,
   output logic             ALUSrc2,
   output logic             ExtOp,
   output logic [4:0]       ALUCtr,
   output logic [1:0]       Data_to_Reg_sel,
   output logic [1:0]       PC_sel,
   output logic             IsJump,
   output logic [2:0]       state,
   output logic             done,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EX  = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_AND = 5'd2;
   localparam logic [4:0] ALU_OR  = 5'd3;
   localparam logic [4:0] ALU_SLT = 5'd4;
   localparam logic [4:0] ALU_SLL = 5'd5;
   localparam logic [4:0] ALU_LUI = 5'd6;

   state_t state_r;

   // Instruction class decode
   logic is_r, is_sll, r_ok;
   logic is_ori, is_addiu, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
   logic is_imm, valid;

   // Raw strobes before reset gating
   logic pcw_s, irw_s, rw_s, mw_s, mr_s;

   assign is_r     = (Op == 6'b000000);
   assign is_sll   = is_r && (Funct == 6'b000000);
   assign r_ok     = is_r && ((Funct == 6'b100001) || (Funct == 6'b100011) ||
                              (Funct == 6'b100100) || (Funct == 6'b100101) ||
                              (Funct == 6'b101010) || (Funct == 6'b000000));
   assign is_ori   = (Op == 6'b001101);
   assign is_addiu = (Op == 6'b001001);
   assign is_lui   = (Op == 6'b001111);
   assign is_lw    = (Op == 6'b100011);
   assign is_sw    = (Op == 6'b101011);
   assign is_beq   = (Op == 6'b000100);
   assign is_j     = (Op == 6'b000010);
   assign is_jal   = (Op == 6'b000011);
   assign is_imm   = is_ori || is_addiu || is_lui;
   assign valid    = r_ok || is_imm || is_lw || is_sw || is_beq || is_j || is_jal;

   // Operand/extension controls depend only on the instruction, not the state
   assign ALUSrc  = is_imm || is_lw || is_sw;
   assign ALUSrc2 = is_sll;
   assign ExtOp   = is_lw || is_sw || is_addiu || is_beq;
   assign state   = state_r;

   // ALU operation select from opcode and, for R-type, the function field
   always_comb begin
      ALUCtr = ALU_ADD;
      case (Op)
         6'b000000: begin
            case (Funct)
               6'b100001: ALUCtr = ALU_ADD;
               6'b100011: ALUCtr = ALU_SUB;
               6'b100100: ALUCtr = ALU_AND;
               6'b100101: ALUCtr = ALU_OR;
               6'b101010: ALUCtr = ALU_SLT;
               6'b000000: ALUCtr = ALU_SLL;
               default:   ALUCtr = ALU_ADD;
            endcase
         end
         6'b000100: ALUCtr = ALU_SUB;
         6'b001101: ALUCtr = ALU_OR;
         6'b001111: ALUCtr = ALU_LUI;
         default:   ALUCtr = ALU_ADD;
      endcase
   end

   // Per-state strobes and selects
   always_comb begin
      pcw_s           = 1'b0;
      irw_s           = 1'b0;
      rw_s            = 1'b0;
      mw_s            = 1'b0;
      mr_s            = 1'b0;
      RegDst          = 2'b00;
      Data_to_Reg_sel = 2'b00;
      PC_sel          = 2'b00;
      IsJump          = 1'b0;
      illegal         = 1'b0;
      case (state_r)
         S_IF: begin
            irw_s = run;
         end
         S_ID: begin
            if (is_j || is_jal) begin
               pcw_s  = 1'b1;
               PC_sel = 2'b10;
               IsJump = 1'b1;
               if (is_jal) begin
                  rw_s            = 1'b1;
                  RegDst          = 2'b10;
                  Data_to_Reg_sel = 2'b10;
               end else begin
                  rw_s = 1'b0;
               end
            end else if (!valid) begin
               // Undecoded: retire as a no-op so the PC still advances
               pcw_s   = 1'b1;
               illegal = 1'b1;
            end else begin
               pcw_s = 1'b0;
            end
         end
         S_EX: begin
            if (is_beq) begin
               pcw_s  = 1'b1;
               PC_sel = Zero ? 2'b01 : 2'b00;
            end else begin
               pcw_s = 1'b0;
            end
         end
         S_MEM: begin
            if (is_lw) begin
               mr_s = 1'b1;
            end else if (is_sw) begin
               mw_s  = 1'b1;
               pcw_s = 1'b1;
            end else begin
               mr_s = 1'b0;
            end
         end
         S_WB: begin
            pcw_s = 1'b1;
            if (is_r) begin
               rw_s   = 1'b1;
               RegDst = 2'b01;
            end else if (is_lw) begin
               rw_s            = 1'b1;
               mr_s            = 1'b1;
               Data_to_Reg_sel = 2'b01;
            end else begin
               rw_s = 1'b1;
            end
         end
         default: begin
            pcw_s = 1'b0;
         end
      endcase
   end

   // Reset suppresses every write strobe so an aborted instruction leaves no trace
   assign PCWrite  = pcw_s && !reset;
   assign IRWrite  = irw_s && !reset;
   assign RegWrite = rw_s  && !reset;
   assign MemWrite = mw_s  && !reset;
   assign MemRead  = mr_s  && !reset;
   assign done     = PCWrite;

   // State sequencing and retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= S_IF;
         instr_cnt <= {CNT_W{1'b0}};
      end else begin
         if (done) begin
            instr_cnt <= instr_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            instr_cnt <= instr_cnt;
         end
         case (state_r)
            S_IF:    state_r <= run ? S_ID : S_IF;
            S_ID:    state_r <= (is_j || is_jal || !valid) ? S_IF : S_EX;
            S_EX: begin
               if (is_r || is_imm) begin
                  state_r <= S_WB;
               end else if (is_lw || is_sw) begin
                  state_r <= S_MEM;
               end else begin
                  state_r <= S_IF;
               end
            end
            S_MEM:   state_r <= is_lw ? S_WB : S_IF;
            S_WB:    state_r <= S_IF;
            default: state_r <= S_IF;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl -- directed self-checking bench for mc_ctrl.
// Inputs change 1 time unit after a rising edge; the combinational outputs
// are checked in the same half-cycle, well before the next edge.
// A second instance with CNT_W=4 shares all inputs to exercise counter wrap.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        reset, run, Zero;
   logic [5:0]  Op, Funct;

   logic        PCWrite, IRWrite, RegWrite, MemWrite, MemRead, ALUSrc, ALUSrc2, ExtOp;
   logic        IsJump, done, illegal;
   logic [1:0]  RegDst, Data_to_Reg_sel, PC_sel;
   logic [4:0]  ALUCtr;
   logic [2:0]  state;
   logic [31:0] instr_cnt;

   logic        PCWrite4, IRWrite4, RegWrite4, MemWrite4, MemRead4, ALUSrc4, ALUSrc24, ExtOp4;
   logic        IsJump4, done4, illegal4;
   logic [1:0]  RegDst4, Data_to_Reg_sel4, PC_sel4;
   logic [4:0]  ALUCtr4;
   logic [2:0]  state4;
   logic [3:0]  instr_cnt4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mc_ctrl u_dut (
      .clk(clk), .reset(reset), .run(run), .Op(Op), .Funct(Funct), .Zero(Zero),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
      .MemRead(MemRead), .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUSrc2(ALUSrc2),
      .ExtOp(ExtOp), .ALUCtr(ALUCtr), .Data_to_Reg_sel(Data_to_Reg_sel),
      .PC_sel(PC_sel), .IsJump(IsJump), .state(state), .done(done),
      .illegal(illegal), .instr_cnt(instr_cnt)
   );

   mc_ctrl #(.CNT_W(4)) u_dut4 (
      .clk(clk), .reset(reset), .run(run), .Op(Op), .Funct(Funct), .Zero(Zero),
      .PCWrite(PCWrite4), .IRWrite(IRWrite4), .RegWrite(RegWrite4), .MemWrite(MemWrite4),
      .MemRead(MemRead4), .RegDst(RegDst4), .ALUSrc(ALUSrc4), .ALUSrc2(ALUSrc24),
      .ExtOp(ExtOp4), .ALUCtr(ALUCtr4), .Data_to_Reg_sel(Data_to_Reg_sel4),
      .PC_sel(PC_sel4), .IsJump(IsJump4), .state(state4), .done(done4),
      .illegal(illegal4), .instr_cnt(instr_cnt4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // state plus the five write strobes; done must always track PCWrite
   task automatic cyc(input string tag, input logic [2:0] st, input logic pcw,
                      input logic irw, input logic rw, input logic mr, input logic mw);
      chk({tag, ".state"},    state,    st);
      chk({tag, ".PCWrite"},  PCWrite,  pcw);
      chk({tag, ".IRWrite"},  IRWrite,  irw);
      chk({tag, ".RegWrite"}, RegWrite, rw);
      chk({tag, ".MemRead"},  MemRead,  mr);
      chk({tag, ".MemWrite"}, MemWrite, mw);
      chk({tag, ".done"},     done,     pcw);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; run = 1'b1; Op = 6'h00; Funct = 6'h21; Zero = 1'b0;
      tick();
      // reset held: IRWrite forced low even though run=1 in IF
      cyc("rst", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst.cnt", instr_cnt, 32'd0);
      reset = 1'b0;
      #1;

      // addu: 0,1,2,4
      cyc("addu.IF", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      cyc("addu.ID", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      cyc("addu.EX", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("addu.ALUCtr", ALUCtr, 32'd0);
      tick();
      cyc("addu.WB", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("addu.RegDst", RegDst, 32'd1);
      chk("addu.DtR", Data_to_Reg_sel, 32'd0);
      tick();
      chk("addu.cnt", instr_cnt, 32'd1);

      // lw: 0,1,2,3,4
      Op = 6'h23;
      cyc("lw.IF", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      cyc("lw.ID", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      cyc("lw.EX", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lw.ALUCtr", ALUCtr, 32'd0);
      chk("lw.ExtOp", ExtOp, 32'd1);
      chk("lw.ALUSrc", ALUSrc, 32'd1);
      tick();
      cyc("lw.MEM", 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      cyc("lw.WB", 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("lw.DtR", Data_to_Reg_sel, 32'd1);
      chk("lw.RegDst", RegDst, 32'd0);
      tick();
      chk("lw.cnt", instr_cnt, 32'd2);

      // beq taken then not taken
      Op = 6'h04; Zero = 1'b1;
      tick(); tick();
      cyc("beqT.EX", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("beqT.PC_sel", PC_sel, 32'd1);
      chk("beqT.ALUCtr", ALUCtr, 32'd1);
      tick();
      chk("beqT.state", state, 32'd0);
      chk("beqT.cnt", instr_cnt, 32'd3);
      Zero = 1'b0;
      tick(); tick();
      cyc("beqN.EX", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("beqN.PC_sel", PC_sel, 32'd0);
      tick();
      chk("beqN.state", state, 32'd0);
      chk("beqN.cnt", instr_cnt, 32'd4);

      // jal: 2 cycles
      Op = 6'h03;
      tick();
      cyc("jal.ID", 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("jal.RegDst", RegDst, 32'd2);
      chk("jal.DtR", Data_to_Reg_sel, 32'd2);
      chk("jal.PC_sel", PC_sel, 32'd2);
      chk("jal.IsJump", IsJump, 32'd1);
      tick();
      chk("jal.state", state, 32'd0);
      chk("jal.cnt", instr_cnt, 32'd5);

      // undecoded opcode retires as a no-op
      Op = 6'h3F;
      tick();
      cyc("ill.ID", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ill.illegal", illegal, 32'd1);
      chk("ill.PC_sel", PC_sel, 32'd0);
      chk("ill.IsJump", IsJump, 32'd0);
      tick();
      chk("ill.state", state, 32'd0);
      chk("ill.cnt", instr_cnt, 32'd6);

      // stall for 3 cycles; decode outputs probed meanwhile
      run = 1'b0; Op = 6'h00; Funct = 6'h00;
      #1;
      cyc("stall0", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sll.ALUSrc2", ALUSrc2, 32'd1);
      chk("sll.ALUCtr", ALUCtr, 32'd5);
      tick();
      Funct = 6'h2A;
      #1;
      cyc("stall1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("slt.ALUSrc2", ALUSrc2, 32'd0);
      chk("slt.ALUCtr", ALUCtr, 32'd4);
      tick();
      Op = 6'h0F;
      #1;
      cyc("stall2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lui.ALUCtr", ALUCtr, 32'd6);
      chk("lui.ALUSrc", ALUSrc, 32'd1);
      chk("lui.ExtOp", ExtOp, 32'd0);
      tick();
      chk("stall.state", state, 32'd0);
      chk("stall.cnt", instr_cnt, 32'd6);

      // sw aborted by reset in MEM
      run = 1'b1; Op = 6'h2B;
      tick(); tick();
      chk("sw.EX.state", state, 32'd2);
      tick();
      cyc("sw.MEM", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      reset = 1'b1;
      #1;
      cyc("sw.rst", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      reset = 1'b0;
      chk("sw.rst.state", state, 32'd0);
      chk("sw.rst.cnt", instr_cnt, 32'd0);

      // ori with run dropped after IF: must not stall
      Op = 6'h0D;
      tick();
      run = 1'b0;
      #1;
      cyc("ori.ID", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      cyc("ori.EX", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ori.ALUCtr", ALUCtr, 32'd3);
      chk("ori.ExtOp", ExtOp, 32'd0);
      tick();
      cyc("ori.WB", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ori.RegDst", RegDst, 32'd0);
      tick();
      cyc("ori.after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("ori.cnt", instr_cnt, 32'd1);

      // counter wrap on the 4-bit instance
      reset = 1'b1;
      tick();
      reset = 1'b0; run = 1'b1; Op = 6'h02;
      #1;
      chk("wrap.cnt4.start", instr_cnt4, 32'd0);
      tick();
      chk("j.IsJump", IsJump, 32'd1);
      chk("j.PC_sel", PC_sel, 32'd2);
      chk("j.RegWrite", RegWrite, 32'd0);
      tick();
      for (int i = 0; i < 14; i++) begin
         tick(); tick();
      end
      chk("wrap.cnt4.15", instr_cnt4, 32'd15);
      chk("wrap.cnt.15", instr_cnt, 32'd15);
      tick(); tick();
      chk("wrap.cnt4.0", instr_cnt4, 32'd0);
      chk("wrap.cnt.16", instr_cnt, 32'd16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of retired-instruction counter.
REQ-002 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-003 SHALL have ports: run in 1, fetch enable; Op in 6, IR[31:26]; Funct in 6, IR[5:0]; Zero in 1, ALU equality flag.
REQ-004 SHALL have outputs: PCWrite 1, IRWrite 1, RegWrite 1, MemWrite 1, MemRead 1 (strobes); RegDst 2 (00 rt, 01 rd, 10 r31).
REQ-005 SHALL have outputs: ALUSrc 1 (1 = extended imm); ALUSrc2 1 (1 = rt as operand A, for sll); ExtOp 1 (1 = sign-extend); ALUCtr 5.
REQ-006 SHALL have outputs: Data_to_Reg_sel 2 (00 ALU, 01 mem, 10 PC+4); PC_sel 2 (00 PC+4, 01 branch, 10 jump); IsJump 1.
REQ-007 SHALL have outputs: state 3, current state; done 1, last cycle of an instruction; illegal 1, undecoded opcode seen; instr_cnt CNT_W, retired-instruction count.

Function
REQ-008 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4; unused encodings SHALL go to IF next cycle with all strobes 0.
REQ-009 IF: IRWrite=1 when run=1, then go to ID; when run=0, stay in IF with IRWrite=0.
REQ-010 ID: j/jal go to IF; undecoded Op (or R-type with undecoded Funct) goes to IF; all others go to EX.
REQ-011 EX: R-type/ori/addiu/lui go to WB; lw/sw go to MEM; beq goes to IF.
REQ-012 MEM: lw goes to WB; sw goes to IF. WB always goes to IF.
REQ-013 Supported decode: Op 000000 with Funct addu 100001, subu 100011, and 100100, or 100101, slt 101010, sll 000000; ori 001101; addiu 001001; lui 001111; lw 100011; sw 101011; beq 000100; j 000010; jal 000011.
REQ-014 ALUCtr encoding SHALL be ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, LUI=6.
REQ-015 ALUCtr selection: lw/sw/addiu use ADD; beq uses SUB; ori uses OR; lui uses LUI; R-type uses the Funct mapping.
REQ-016 ExtOp=1 SHALL apply for lw/sw/addiu/beq; ExtOp=0 otherwise.
REQ-017 ALUSrc=1 for ori/addiu/lui/lw/sw; ALUSrc2=1 only for sll.
REQ-018 All outputs SHALL be combinational functions of state, Op, Funct and Zero; strobes SHALL be 0 in every state not listed below.
REQ-019 PCWrite=1 exactly once per instruction, in its last state; PC is not advanced in IF.
REQ-020 EX, beq: PCWrite=1; PC_sel=01 if Zero=1, else 00.
REQ-021 ID, j: PCWrite=1, PC_sel=10, IsJump=1.
REQ-022 ID, jal: j behaviour plus RegWrite=1, RegDst=10, Data_to_Reg_sel=10.
REQ-023 ID, undecoded instruction: PCWrite=1, PC_sel=00, illegal=1, no other strobes.
REQ-024 MEM: MemRead=1 for lw; for sw, MemWrite=1, PCWrite=1, PC_sel=00.
REQ-025 WB, R-type: RegWrite=1, RegDst=01, Data_to_Reg_sel=00.
REQ-026 WB, immediate ops: RegDst=00, Data_to_Reg_sel=00. WB, lw: RegDst=00, Data_to_Reg_sel=01, MemRead=1. In every WB case, PCWrite=1, PC_sel=00.
REQ-027 done SHALL equal PCWrite.
REQ-028 instr_cnt SHALL increment by 1 on each clock edge where done=1 and reset=0, wrapping from all-ones to 0.
REQ-029 Latencies in cycles: j/jal/illegal 2, beq 3, R-type/imm/sw 4, lw 5; each IF stall cycle (run=0) adds 1.
REQ-030 run SHALL be sampled only in IF; deasserting run mid-instruction SHALL NOT stall it.

Reset
REQ-031 With reset=1 at a rising edge: state becomes IF and instr_cnt becomes 0, regardless of current state.
REQ-032 While reset=1, PCWrite, IRWrite, RegWrite, MemWrite, MemRead and done SHALL be forced to 0 combinationally. This aborts any in-flight instruction with no partial register or memory write.
REQ-033 After reset deasserts, the first IF cycle with run=1 SHALL assert IRWrite.

Verification
REQ-034 addu (Op 0, Funct 100001), run=1 -> states 0,1,2,4,0; RegWrite=1 only in cycle 4 with RegDst=01; instr_cnt 0->1.
REQ-035 lw -> states 0,1,2,3,4; MemRead=1 in MEM and WB; Data_to_Reg_sel=01 in WB; PCWrite only in WB.
REQ-036 beq with Zero=1, then with Zero=0 -> 3 cycles each; EX PC_sel=01, then 00; PCWrite=1 in EX both times.
REQ-037 jal -> 2 cycles; in ID: RegWrite=1, RegDst=10, Data_to_Reg_sel=10, PC_sel=10, IsJump=1. Op=111111 -> illegal=1 in ID, no writes, instr_cnt +1.
REQ-038 run=0 for 3 cycles -> state stays 0 and IRWrite=0. Reset asserted during MEM of sw -> MemWrite=0 that cycle; next state 0; instr_cnt=0.
REQ-039 With CNT_W=4, retire 16 j instructions -> instr_cnt wraps 15->0.
